// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface fetch_if #(
    parameter int N = 32
) ();

    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [N-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_resp_buf.sv
// One-entry holding buffer for a fetched instruction and its PC while decode is stalled.
module fetch_resp_buf #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic [N-1:0] instr_i,
    input  logic [N-1:0] pc_i,
    output logic         valid_o,
    output logic [N-1:0] instr_o,
    output logic [N-1:0] pc_o
);

    logic         valid_q;
    logic [N-1:0] instr_q;
    logic [N-1:0] pc_q;

    // Flush wins: it is used both for draining into IF/ID and for discarding on redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, IF/ID registers.
// Optional FETCH_PERF_EN adds fetch_cnt / redirect_cnt performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PC_sel,
    input  logic [N-1:0] branch_target,
    input  logic         ifRegEn,
    fetch_if.master      imem,
    output logic [N-1:0] instr_out,
    output logic [N-1:0] PC_out,
    output logic [N-1:0] NPC_out,
    output logic         valid_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  fetch_cnt,
    output logic [31:0]  redirect_cnt
`endif
);

    localparam logic [N-1:0] STEP      = N'(PC_STEP);
    localparam logic [N-1:0] ALIGN_MSK = ~N'(PC_STEP - 1);

    fetch_state_t state_q, state_d;
    logic [N-1:0] fetchPc_q, fetchPc_d;
    logic [N-1:0] reqPc_q, reqPc_d;
    logic         dropFlag_q, dropFlag_d;
    logic [N-1:0] instr_q, instr_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] npc_q, npc_d;
    logic         valid_q, valid_d;

    logic         granted, respIn, respTake;
    logic         loadDirect, bufLoad, bufDrain, bufFlush;
    logic         bufValid;
    logic [N-1:0] bufInstr, bufPc;

    fetch_resp_buf #(.N(N)) u_resp_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (bufLoad),
        .flush_i (bufFlush),
        .instr_i (imem.imem_rdata),
        .pc_i    (reqPc_q),
        .valid_o (bufValid),
        .instr_o (bufInstr),
        .pc_o    (bufPc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetchPc_q  <= RESET_PC;
            reqPc_q    <= '0;
            dropFlag_q <= 1'b0;
            instr_q    <= N'(NOP_INSTR);
            pc_q       <= '0;
            npc_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            reqPc_q    <= reqPc_d;
            dropFlag_q <= dropFlag_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            valid_q    <= valid_d;
        end
    end

    // A response is only usable when it is not orphaned and no redirect is arriving with it.
    always_comb begin
        imem.imem_req  = (state_q == REQ);
        imem.imem_addr = fetchPc_q;
        granted        = (state_q == REQ) && imem.imem_gnt;
        respIn         = (state_q == WAIT) && imem.imem_rvalid;
        respTake       = respIn && !dropFlag_q && !PC_sel;
        loadDirect     = respTake && ifRegEn;
        bufLoad        = respTake && !ifRegEn;
        bufDrain       = (state_q == HOLD) && bufValid && ifRegEn && !PC_sel;
        bufFlush       = (state_q == HOLD) && (PC_sel || ifRegEn);
    end

    always_comb begin
        state_d    = state_q;
        fetchPc_d  = fetchPc_q;
        reqPc_d    = reqPc_q;
        dropFlag_d = dropFlag_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (granted) begin
                    state_d    = WAIT;
                    reqPc_d    = fetchPc_q;
                    fetchPc_d  = fetchPc_q + STEP;
                    dropFlag_d = PC_sel;
                end
            end
            WAIT: begin
                if (respIn) begin
                    state_d    = bufLoad ? HOLD : REQ;
                    dropFlag_d = 1'b0;
                end else if (PC_sel) begin
                    dropFlag_d = 1'b1;
                end
            end
            HOLD: begin
                if (PC_sel || ifRegEn) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (loadDirect) begin
            instr_d = imem.imem_rdata;
            pc_d    = reqPc_q;
            npc_d   = reqPc_q + STEP;
            valid_d = 1'b1;
        end else if (bufDrain) begin
            instr_d = bufInstr;
            pc_d    = bufPc;
            npc_d   = bufPc + STEP;
            valid_d = 1'b1;
        end

        if (PC_sel) begin
            fetchPc_d = branch_target & ALIGN_MSK;
            instr_d   = N'(NOP_INSTR);
            pc_d      = '0;
            npc_d     = '0;
            valid_d   = 1'b0;
        end
    end

    assign instr_out = instr_q;
    assign PC_out    = pc_q;
    assign NPC_out   = npc_q;
    assign valid_out = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetchCnt_q, redirectCnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetchCnt_q    <= '0;
            redirectCnt_q <= '0;
        end else begin
            fetchCnt_q    <= fetchCnt_q + 32'(loadDirect || bufDrain);
            redirectCnt_q <= redirectCnt_q + 32'(PC_sel);
        end
    end

    assign fetch_cnt    = fetchCnt_q;
    assign redirect_cnt = redirectCnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, then randomized traffic against a
// transaction-level model of the fetch stream (expected fetch address, IF/ID contents).
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_sel;
    logic        ifRegEn;
    logic [31:0] branch_target;
    logic [31:0] instr_out, PC_out, NPC_out;
    logic        valid_out;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCnt, redirectCnt;
`endif

    fetch_if #(.N(32)) bus ();

    fetch_stage #(.N(32), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_sel        (PC_sel),
        .branch_target (branch_target),
        .ifRegEn       (ifRegEn),
        .imem          (bus),
        .instr_out     (instr_out),
        .PC_out        (PC_out),
        .NPC_out       (NPC_out),
        .valid_out     (valid_out)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt     (fetchCnt),
        .redirect_cnt  (redirectCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        bit          orphan;
        int          due;
    } txn_t;

    txn_t        inflight[$];
    txn_t        resp;
    int          checks = 0;
    int          errors = 0;
    int          cycleNo = 0;
    int          gntPct = 100;
    int          latMin = 1;
    int          latMax = 1;

    logic [31:0] expInstr, expPc, expNpc, nextFetch, pendAddr;
    bit          expValid, expPcKnown, pendValid;
    int          modelFetchCnt, modelRedirCnt;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock: memory responds, the reference model advances, then IF/ID is compared.
    task automatic applyStimulus();
        bit respHit = 0;
        bit busy = 0;
        bit grant = 0;
        foreach (inflight[i]) if (!inflight[i].orphan) busy = 1;
        bus.imem_rvalid = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rdata  = $urandom;
        if (inflight.size() > 0 && inflight[0].due <= cycleNo) begin
            resp            = inflight.pop_front();
            respHit         = 1;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memWord(resp.addr);
        end
        if (bus.imem_req === 1'b1 && inflight.size() == 0 && $urandom_range(99) < gntPct) begin
            bus.imem_gnt = 1'b1;
            grant        = 1;
            inflight.push_back('{addr: bus.imem_addr, stale: 0, orphan: 0,
                                 due: cycleNo + $urandom_range(latMax, latMin)});
        end

        if (!rst) begin
            foreach (inflight[i]) inflight[i].orphan = 1;
            pendValid     = 0;
            expInstr      = NOP;
            expPc         = 32'h0;
            expNpc        = 32'h0;
            expValid      = 0;
            expPcKnown    = 1;
            nextFetch     = RST_PC;
            modelFetchCnt = 0;
            modelRedirCnt = 0;
        end else begin
            if (bus.imem_req === 1'b1) begin
                checkOutput("reqWhileBusy", 32'(busy), 32'h0);
                checkOutput("reqWhileHeld", 32'(pendValid), 32'h0);
            end
            if (grant) checkOutput("grantAddr", bus.imem_addr, nextFetch);
            if (PC_sel) begin
                foreach (inflight[i]) inflight[i].stale = 1;
                pendValid  = 0;
                expInstr   = NOP;
                expValid   = 0;
                expPcKnown = 0;
                nextFetch  = {branch_target[31:2], 2'b00};
                modelRedirCnt++;
            end else begin
                if (respHit && !resp.stale && !resp.orphan) begin
                    pendValid = 1;
                    pendAddr  = resp.addr;
                end
                if (pendValid && ifRegEn) begin
                    expInstr   = memWord(pendAddr);
                    expPc      = pendAddr;
                    expNpc     = pendAddr + 32'd4;
                    expValid   = 1;
                    expPcKnown = 1;
                    pendValid  = 0;
                    modelFetchCnt++;
                end
                if (grant) nextFetch = nextFetch + 32'd4;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cycleNo++;
        checkOutput("instr_out", instr_out, expInstr);
        checkOutput("valid_out", 32'(valid_out), 32'(expValid));
        if (expPcKnown) begin
            checkOutput("PC_out", PC_out, expPc);
            checkOutput("NPC_out", NPC_out, expNpc);
        end
    endtask

    initial begin
        rst            = 1'b0;
        PC_sel         = 1'b0;
        ifRegEn        = 1'b1;
        branch_target  = 32'h0;
        bus.imem_gnt   = 1'b0;
        bus.imem_rvalid= 1'b0;
        bus.imem_rdata = 32'h0;

        // Reset, then zero-wait memory: one instruction every two cycles.
        applyStimulus();
        applyStimulus();
        rst = 1'b1;
        checkOutput("reqAfterRelease", 32'(bus.imem_req), 32'h0);
        applyStimulus();
        checkOutput("firstReq", 32'(bus.imem_req), 32'h1);
        checkOutput("firstAddr", bus.imem_addr, 32'h0);
        applyStimulus();
        applyStimulus();
        checkOutput("instr0", instr_out, 32'h00A0_0093);
        checkOutput("npc0", NPC_out, 32'h4);
        checkOutput("addr1", bus.imem_addr, 32'h4);
        applyStimulus();
        applyStimulus();
        checkOutput("instr1", instr_out, 32'h0010_0113);
        checkOutput("pc1", PC_out, 32'h4);
        checkOutput("npc1", NPC_out, 32'h8);

        // Stall when the response arrives: buffered, no new request, released later.
        ifRegEn = 1'b0;
        applyStimulus();
        applyStimulus();
        for (int i = 0; i < 2; i++) begin
            checkOutput("holdNoReq", 32'(bus.imem_req), 32'h0);
            checkOutput("holdInstr", instr_out, 32'h0010_0113);
            applyStimulus();
        end
        checkOutput("holdNoReq", 32'(bus.imem_req), 32'h0);
        ifRegEn = 1'b1;
        applyStimulus();
        checkOutput("releaseInstr", instr_out, memWord(32'h8));
        checkOutput("releasePc", PC_out, 32'h8);

        // Redirect while waiting; the late response must be discarded.
        latMin = 3; latMax = 3;
        applyStimulus();
        PC_sel = 1'b1; branch_target = 32'h100;
        applyStimulus();
        PC_sel = 1'b0;
        checkOutput("flushValid", 32'(valid_out), 32'h0);
        checkOutput("flushInstr", instr_out, NOP);
        checkOutput("waitNoReq", 32'(bus.imem_req), 32'h0);
        applyStimulus();
        applyStimulus();
        checkOutput("redirReq", 32'(bus.imem_req), 32'h1);
        checkOutput("redirAddr", bus.imem_addr, 32'h100);
        latMin = 1; latMax = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("redirInstr", instr_out, memWord(32'h100));

        // Redirect coincident with a grant for 0x8; target 0x202 aligns to 0x200.
        gntPct = 0; PC_sel = 1'b1; branch_target = 32'h8;
        applyStimulus();
        checkOutput("reqAt8", bus.imem_addr, 32'h8);
        gntPct = 100; branch_target = 32'h202;
        applyStimulus();
        PC_sel = 1'b0;
        checkOutput("orphanNoReq", 32'(bus.imem_req), 32'h0);
        applyStimulus();
        checkOutput("alignedAddr", bus.imem_addr, 32'h200);
        checkOutput("orphanValid", 32'(valid_out), 32'h0);
        applyStimulus();
        applyStimulus();
        checkOutput("pc200", PC_out, 32'h200);
        checkOutput("npc200", NPC_out, 32'h204);

        // Reset during WAIT; the stray response after release is ignored.
        latMin = 3; latMax = 3;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        rst = 1'b1;
        checkOutput("rstValid", 32'(valid_out), 32'h0);
        applyStimulus();
        checkOutput("rstReq", 32'(bus.imem_req), 32'h1);
        checkOutput("rstAddr", bus.imem_addr, RST_PC);

        // PC wrap at the top of the address space.
        latMin = 1; latMax = 1;
        gntPct = 0; PC_sel = 1'b1; branch_target = 32'hFFFF_FFFE;
        applyStimulus();
        PC_sel = 1'b0; gntPct = 100;
        checkOutput("topAddr", bus.imem_addr, 32'hFFFF_FFFC);
        applyStimulus();
        applyStimulus();
        checkOutput("wrapNpc", NPC_out, 32'h0);
        checkOutput("wrapAddr", bus.imem_addr, 32'h0);

        // Randomized traffic.
        gntPct = 60; latMin = 1; latMax = 4;
        for (int i = 0; i < 4000; i++) begin
            ifRegEn       = ($urandom_range(99) < 70);
            PC_sel        = ($urandom_range(99) < 6);
            branch_target = $urandom;
            rst           = !($urandom_range(999) < 4);
            applyStimulus();
        end
        rst = 1'b1; PC_sel = 1'b0; ifRegEn = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus();

`ifdef FETCH_PERF_EN
        checkOutput("fetchCnt", fetchCnt, 32'(modelFetchCnt));
        checkOutput("redirectCnt", redirectCnt, 32'(modelRedirCnt));
`endif
        $display("[TB] model loads %0d redirects %0d since last reset", modelFetchCnt, modelRedirCnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V-lite pipeline: owns the program counter, issues requests to instruction memory, and loads the IF/ID pipeline registers. It consumes the branch-redirect signal `PC_sel` and the branch target produced by the memory stage, and sits at the head of the pipeline feeding decode. One request is outstanding at a time; redirects flush IF/ID and discard any in-flight response.

## Interface
- `N`, 32: datapath/address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `PC_sel` in 1: redirect request from memory stage (branch taken).
- `branch_target` in N: redirect address, valid when `PC_sel`=1.
- `ifRegEn` in 1: IF/ID load enable from control unit; 0 = stall.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out N: fetch address, word aligned.
- `imem_gnt` in 1: memory accepts request this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in N: instruction word.
- `instr_out` out N: IF/ID instruction.
- `PC_out` out N: IF/ID PC of `instr_out`.
- `NPC_out` out N: IF/ID PC+4.
- `valid_out` out 1: IF/ID holds a real instruction.

## Operation
- Reset (`rst`=0 at edge): `fetch_pc`=RESET_PC, state IDLE, `imem_req`=0, `instr_out`=32'h0000_0013 (NOP), `PC_out`=0, `NPC_out`=0, `valid_out`=0, drop flag=0, buffer empty. Reset mid-transaction abandons it; late `imem_rvalid` after reset is ignored (drop flag cleared, state not WAIT).
- FSM: IDLE -> REQ (unconditional, one cycle). REQ: `imem_req`=1, `imem_addr`=`fetch_pc`; on `imem_gnt`: `req_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4, -> WAIT. WAIT: on `imem_rvalid`: if `ifRegEn`=1 load IF/ID (`instr_out`=rdata, `PC_out`=`req_pc`, `NPC_out`=`req_pc`+4, `valid_out`=1), -> REQ; else capture into one-entry buffer, -> HOLD. HOLD: when `ifRegEn`=1 load IF/ID from buffer, -> REQ.
- Memory protocol: request and address sampled only in the `imem_gnt` cycle; address may change between non-granted cycles. Exactly one `imem_rvalid` per grant, any latency >=1.
- Stall: `ifRegEn`=0 holds all IF/ID outputs unchanged (absent redirect).
- Redirect (`PC_sel`=1), highest priority, independent of `ifRegEn`: IF/ID loads NOP, `valid_out`=0; `fetch_pc`<=`{branch_target[N-1:2],2'b00}`. Per state: IDLE/REQ -> REQ (a grant in the same cycle is orphaned: drop flag set, -> WAIT); WAIT -> drop flag set, stays WAIT unless `imem_rvalid` same cycle (response discarded, -> REQ); HOLD -> buffer discarded, -> REQ.
- Drop flag set in WAIT: next `imem_rvalid` discarded, flag cleared, -> REQ.
- PC arithmetic modulo 2^N; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- IF/ID outputs registered: update one edge after `imem_rvalid` (or after `ifRegEn` rise in HOLD).
- `imem_req` registered from state; first request the second cycle after reset release.
- Zero-wait memory (gnt in REQ cycle, rvalid next cycle): one instruction per 2 cycles.
- `PC_sel` at cycle t: IF/ID flushed at t+1; `imem_addr`=target with `imem_req`=1 at t+1 (from IDLE/REQ/HOLD) or the cycle after the dropped response (from WAIT).

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `fetch_cnt` (32) counting IF/ID loads with `valid_out`=1, and `redirect_cnt` (32) counting `PC_sel` cycles; both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package `fetch_pkg`: `fetch_state_t` (IDLE, REQ, WAIT, HOLD), `NOP_INSTR`=32'h0000_0013, `PC_STEP`=4.
- One sub-module: `fetch_resp_buf`, one-entry instruction/PC buffer with load, flush, valid.
- IF/ID registers local (need synchronous NOP load on flush).

## Test plan
- Reset release, zero-wait memory returning 0x00A00093, 0x00100113 -> `imem_addr` 0x0, 0x4; `instr_out` sequence matches, `PC_out` 0x0/0x4, `NPC_out` 0x4/0x8, `valid_out`=1.
- `ifRegEn`=0 when `imem_rvalid` arrives, held 3 cycles -> state HOLD, IF/ID unchanged, no new `imem_req`; on release IF/ID loads buffered word next edge.
- `PC_sel`=1, `branch_target`=0x100 in WAIT with rvalid 2 cycles later -> response discarded, `valid_out`=0/NOP, next granted address 0x100.
- `PC_sel` same cycle as `imem_gnt` for 0x8 -> 0x8 response dropped, next request 0x200 (target 0x202 aligned to 0x200).
- `rst`=0 in WAIT, stray `imem_rvalid` after release -> ignored, first request at RESET_PC; `fetch_pc` 0xFFFF_FFFC wraps to 0x0.
